instr_prefetch_buffer: RTL

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

---
 rtl/instr_prefetch_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: a small FIFO of {word address, data} pairs
// fed by sequential memory reads, serving core fetches with a one-cycle hit
// latency. Misses and flushes redirect the prefetch stream; a read that is
// already in flight is allowed to complete and is dropped.
module instr_prefetch_buffer #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h00000000,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    input  logic        instr_flush_i,
    output logic        instr_rsp_o,
    output logic [31:0] instr_data_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rsp_i,
    input  logic [31:0] mem_data_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [29:0]      fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [0:0]       state;
    logic             discard;
    logic             prefetch_en;
    logic [31:0]      fetch_addr;

    logic        req_act;
    logic        head_match;
    logic        pend_match;
    logic        hit;
    logic        miss;
    logic        redirect;
    logic        got_rsp;
    logic        push;
    logic        issue;
    logic [31:0] miss_addr;
    logic [31:0] issue_addr;

    // Request is ignored in the cycle its predecessor is answered, so a held
    // request is re-evaluated against the next head entry one cycle later.
    assign req_act    = instr_req_i && !instr_rsp_o && !instr_flush_i;
    assign miss_addr  = instr_addr_i & 32'hFFFF_FFFC;
    assign head_match = (count != '0) && (fifo_addr[rd_ptr] == miss_addr[31:2]);
    // An empty FIFO still waits if the live (non-discarded) read is the target.
    assign pend_match = (state == S_WAIT) && !discard && (mem_addr_o[31:2] == miss_addr[31:2]);
    assign hit        = req_act && head_match;
    assign miss       = req_act && !head_match && !((count == '0) && pend_match);
    assign redirect   = instr_flush_i || miss;
    assign got_rsp    = (state == S_WAIT) && mem_rsp_i;
    assign push       = got_rsp && !discard && !redirect;
    // Only one read in flight, so count < DEPTH in IDLE guarantees room for it.
    assign issue      = (state == S_IDLE) && !instr_flush_i &&
                        (miss || (prefetch_en && (count < DEPTH_C)));
    assign issue_addr = miss ? miss_addr : fetch_addr;
    assign mem_req_o  = (state == S_WAIT);

    // Control path: FIFO bookkeeping, fetch FSM, redirect handling, core response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            state        <= S_IDLE;
            discard      <= 1'b0;
            prefetch_en  <= 1'b1;
            fetch_addr   <= BOOT_ADDRESS;
            mem_addr_o   <= 32'h0;
            instr_rsp_o  <= 1'b0;
            instr_data_o <= 32'h0;
        end else begin
            instr_rsp_o <= hit;
            if (hit) begin
                instr_data_o <= fifo_data[rd_ptr];
            end

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (hit) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(push) - CNT_W'(hit);
            end

            if (got_rsp) begin
                state <= S_IDLE;
            end else if (issue) begin
                state      <= S_WAIT;
                mem_addr_o <= issue_addr;
            end

            if (issue) begin
                fetch_addr <= issue_addr + 32'd4;
            end else if (miss) begin
                fetch_addr <= miss_addr;
            end

            if (got_rsp) begin
                discard <= 1'b0;
            end else if (redirect && (state == S_WAIT)) begin
                discard <= 1'b1;
            end

            if (instr_flush_i) begin
                prefetch_en <= 1'b0;
            end else if (miss) begin
                prefetch_en <= 1'b1;
            end
        end
    end

    // FIFO storage: written on accepted memory responses, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mem_addr_o[31:2];
            fifo_data[wr_ptr] <= mem_data_i;
        end
    end

endmodule
